plan_eval: RTL and testbench
============================

# plan_eval

Evaluates the piecewise-linear activation segment y = cf1·x + cf2 in IEEE-754 single precision. It consumes the input sample and the slope/intercept pair produced by the coefficient stage and returns the activation value. The block is a 4-stage pipelined multiply-add with a valid strobe. It sits directly downstream of the coefficient generator in the activation accelerator datapath.

## Interface
- No parameters; all widths fixed at FP32.
- clk  in  1  single clock, all state on rising edge.
- res  in  1  reset, asynchronous, active-high.
- in_valid  in  1  x/cf1/cf2 hold a coherent triple this cycle.
- x  in  32  FP32 input sample.
- cf1  in  32  FP32 slope.
- cf2  in  32  FP32 intercept.
- out_valid  out  1  y holds a new result this cycle.
- y  out  32  FP32 result cf1·x + cf2.

## Operation
- Operand handling:
  - Denormal inputs are flushed to zero.
  - Exponent 255 (Inf/NaN) is not produced upstream; it is treated as exponent 254. No special NaN path.
- S1 (capture): register x, cf1, cf2 and in_valid. Unpack sign, exponent and the 24-bit mantissa with the hidden bit. Flag zero operands.
- S2 (multiply):
  - Product sign = sx ^ s1.
  - Product exponent = ex + e1 − 127, kept 10-bit signed.
  - Mantissa: 24×24 → 48-bit product.
  - If either factor is zero, the product is zero.
- S3 (align): normalize the product to 1.xxx by a 1-bit shift on bit 47. Align the smaller-exponent operand right by the exponent difference. The shift saturates at 27. Retain guard, round and sticky bits, with sticky being the OR of all bits shifted out.
- S4 (add/normalize/round):
  - Add or subtract the aligned magnitudes according to the signs.
  - Renormalize with a leading-zero count (left shift up to 26) or a 1-bit right shift on carry.
  - Round per Configuration and pack into y.
- Result rules:
  - Exact cancellation → +0 (0x00000000).
  - Exponent ≤ 0 after normalize → signed zero.
  - Exponent ≥ 255 → signed max finite (0x7F7FFFFF / 0xFF7FFFFF).
  - A zero product passes cf2 through unchanged (flushed if denormal).
  - A zero cf2 gives the rounded product.
- There is no backpressure: the block accepts one triple per cycle, every cycle.

## Timing
- Latency is 4 cycles: a triple sampled with in_valid at edge t gives out_valid=1 with y valid after edge t+4.
- Throughput is 1 per cycle. Back-to-back in_valid produces back-to-back out_valid in input order.
- y updates only when out_valid rises with a new result. Otherwise y holds its last value.
- Reset values: y=0x00000000, out_valid=0, and all internal stage valids=0.
- res asserted mid-operation clears every stage at once. In-flight triples are discarded and never emerge. The first valid after release takes the full 4 cycles.
- Inputs are don't-care while in_valid=0.

## Configuration
- PLAN_EVAL_RNE_EN defined: round-to-nearest-even using G/R/S. A mantissa carry-out from rounding increments the exponent, with overflow saturation as above.
- Not defined: truncation (round toward zero). G/R/S are ignored at pack and the rounding incrementer is not built.
- Latency is 4 in both builds.

## Structure
- Package plan_eval_pkg holds:
  - fp32 struct typedef {sign, exp[7:0], man[22:0]}.
  - Constants FP_BIAS=127, FP_MAX_POS=0x7F7FFFFF, PLAN_EVAL_LAT=4, ALIGN_SAT=27.
  - Unpack/pack functions.
- One sub-module, plan_fp_norm: leading-zero count plus normalizing shifter on the 27-bit sum, returning the shift amount and the shifted mantissa. It is reusable by later FP blocks.

## Test plan
- Zero input: x=0x00000000, cf1=0x3E7ECE00, cf2=0x3F000442, single in_valid → 4 cycles later out_valid=1, y=0x3F000442.
- Exact sum: x=0x3F800000 (1.0), cf1=0x3E800000 (0.25), cf2=0x3F000000 (0.5) → y=0x3F400000 (0.75) at latency 4.
- Cancellation: x=0xC0000000 (−2.0), cf1=0x3E800000, cf2=0x3F000000 → y=0x00000000.
- Negative-zero slope: x=0x40800000, cf1=0x80000000, cf2=0x3F800000 → y=0x3F800000.
- Streaming: 8 consecutive in_valid cycles with distinct triples → 8 consecutive out_valid cycles, in order, each matching the reference model bit-exactly in the configured rounding mode.
- Reset mid-flight: 3 triples in flight, pulse res for 1 cycle (asynchronous, mid-cycle) → out_valid=0 and y=0 immediately; no stale results appear afterwards. A new triple after release emerges 4 cycles later.

Source files
------------

// File: rtl/plan_eval_pkg.sv
// Shared FP32 types, constants and unpack/pack helpers for the plan_eval datapath.
package plan_eval_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  // Unpacked operand: mantissa carries the hidden bit, zero covers flushed denormals.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] man;
    logic        zero;
  } fp_unp_t;

  localparam int unsigned FP_BIAS       = 127;
  localparam logic [31:0] FP_MAX_POS    = 32'h7F7F_FFFF;
  localparam int unsigned PLAN_EVAL_LAT = 4;
  localparam int unsigned ALIGN_SAT     = 27;

  function automatic fp_unp_t fp_unpack(input logic [31:0] v);
    fp32_t   f;
    fp_unp_t u;
    f      = fp32_t'(v);
    u.sign = f.sign;
    u.zero = (f.exp == 8'd0);
    // Inf/NaN never arrive from upstream; the top exponent is folded onto 254.
    u.exp  = (f.exp == 8'hFF) ? 8'hFE : f.exp;
    u.man  = u.zero ? 24'd0 : {1'b1, f.man};
    return u;
  endfunction

  function automatic logic [31:0] fp_pack(input logic sign, input logic [7:0] exp,
                                          input logic [22:0] man);
    fp32_t f;
    f.sign = sign;
    f.exp  = exp;
    f.man  = man;
    return 32'(f);
  endfunction

endpackage

// File: rtl/plan_fp_norm.sv
// Leading-zero count and normalizing left shift of a 27-bit mantissa (1.23 + G/R/S).
module plan_fp_norm (
  input  logic [26:0] man_i,
  output logic [4:0]  shamt_o,
  output logic [26:0] man_o
);

  // Highest set bit wins; an all-zero input reports a shift of 0.
  always_comb begin
    shamt_o = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (man_i[i]) shamt_o = 5'(26 - i);
    end
    man_o = man_i << shamt_o;
  end

endmodule

// File: rtl/plan_eval.sv
// Four-stage FP32 multiply-add y = cf1*x + cf2 with valid strobe.
// Rounding: PLAN_EVAL_RNE_EN selects round-to-nearest-even, otherwise truncation.
module plan_eval
  import plan_eval_pkg::*;
(
  input  logic        clk,
  input  logic        res,
  input  logic        in_valid,
  input  logic [31:0] x,
  input  logic [31:0] cf1,
  input  logic [31:0] cf2,
  output logic        out_valid,
  output logic [31:0] y
);

  logic    v1_q;
  fp_unp_t ux_q, u1_q, uc1_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      v1_q  <= 1'b0;
      ux_q  <= '0;
      u1_q  <= '0;
      uc1_q <= '0;
    end else begin
      v1_q  <= in_valid;
      ux_q  <= fp_unpack(x);
      u1_q  <= fp_unpack(cf1);
      uc1_q <= fp_unpack(cf2);
    end
  end

  logic              v2_q, sp_q, zp_q;
  logic signed [9:0] ep_q;
  logic [47:0]       mp_q;
  fp_unp_t           uc2_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      v2_q  <= 1'b0;
      sp_q  <= 1'b0;
      zp_q  <= 1'b0;
      ep_q  <= '0;
      mp_q  <= '0;
      uc2_q <= '0;
    end else begin
      v2_q  <= v1_q;
      sp_q  <= ux_q.sign ^ u1_q.sign;
      zp_q  <= ux_q.zero | u1_q.zero;
      ep_q  <= $signed({2'b00, ux_q.exp}) + $signed({2'b00, u1_q.exp})
               - $signed(10'(FP_BIAS));
      mp_q  <= 48'(ux_q.man) * 48'(u1_q.man);
      uc2_q <= uc1_q;
    end
  end

  logic [26:0]       pn, cm, mb, ms, ma;
  logic signed [9:0] pe, ce, eb, es, diff;
  logic              sb, ss, swap;
  logic [4:0]        sh;
  logic [53:0]       wide;

  always_comb begin
    if (mp_q[47]) begin
      pn = {mp_q[47:24], mp_q[23:22], |mp_q[21:0]};
      pe = ep_q + 10'sd1;
    end else begin
      pn = {mp_q[46:23], mp_q[22:21], |mp_q[20:0]};
      pe = ep_q;
    end
    cm = {uc2_q.man, 3'b000};
    ce = $signed({2'b00, uc2_q.exp});
    // A zero product always yields to cf2; a zero cf2 always yields to the product.
    swap = zp_q | (!uc2_q.zero & ((ce > pe) | ((ce == pe) & (cm > pn))));
    if (swap) begin
      sb = uc2_q.sign; eb = ce; mb = cm;
      ss = sp_q;       es = pe; ms = pn;
    end else begin
      sb = sp_q;       eb = pe; mb = pn;
      ss = uc2_q.sign; es = ce; ms = cm;
    end
    diff = eb - es;
    sh   = (diff > $signed(10'(ALIGN_SAT))) ? 5'(ALIGN_SAT) : diff[4:0];
    wide = {ms, 27'd0} >> sh;
    ma   = {wide[53:28], wide[27] | (|wide[26:0])};
  end

  logic              v3_q, sb3_q, sub3_q, zp3_q;
  logic signed [9:0] eb3_q;
  logic [26:0]       mb3_q, ma3_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      v3_q   <= 1'b0;
      sb3_q  <= 1'b0;
      sub3_q <= 1'b0;
      zp3_q  <= 1'b0;
      eb3_q  <= '0;
      mb3_q  <= '0;
      ma3_q  <= '0;
    end else begin
      v3_q   <= v2_q;
      sb3_q  <= sb;
      sub3_q <= sb ^ ss;
      zp3_q  <= zp_q;
      eb3_q  <= eb;
      mb3_q  <= mb;
      ma3_q  <= ma;
    end
  end

  logic              v4_q, s4_q, zp4_q;
  logic signed [9:0] e4_q;
  logic [27:0]       sum4_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      v4_q   <= 1'b0;
      s4_q   <= 1'b0;
      zp4_q  <= 1'b0;
      e4_q   <= '0;
      sum4_q <= '0;
    end else begin
      v4_q   <= v3_q;
      s4_q   <= sb3_q;
      zp4_q  <= zp3_q;
      e4_q   <= eb3_q;
      sum4_q <= sub3_q ? ({1'b0, mb3_q} - {1'b0, ma3_q}) : ({1'b0, mb3_q} + {1'b0, ma3_q});
    end
  end

  logic [4:0]        shamt;
  logic [26:0]       norm_man, mn;
  logic signed [9:0] en, er;
  logic [22:0]       frac;
  logic [31:0]       y_d;

  plan_fp_norm u_norm (
    .man_i   (sum4_q[26:0]),
    .shamt_o (shamt),
    .man_o   (norm_man)
  );

`ifdef PLAN_EVAL_RNE_EN
  logic        inc;
  logic [24:0] mr;
`else
  logic unused_grs;
  assign unused_grs = ^{mn[26], mn[2:0]};
`endif

  always_comb begin
    if (sum4_q[27]) begin
      mn = {sum4_q[27:2], |sum4_q[1:0]};
      en = e4_q + 10'sd1;
    end else begin
      mn = norm_man;
      en = e4_q - $signed({5'b00000, shamt});
    end
`ifdef PLAN_EVAL_RNE_EN
    inc  = mn[2] & (mn[3] | mn[1] | mn[0]);
    mr   = {1'b0, mn[26:3]} + {24'd0, inc};
    frac = mr[24] ? mr[23:1] : mr[22:0];
    er   = mr[24] ? en + 10'sd1 : en;
`else
    frac = mn[25:3];
    er   = en;
`endif
    // Exact cancellation gives +0; only a zero product keeps the sign of a zero cf2.
    if (sum4_q == '0)          y_d = zp4_q ? {s4_q, 31'd0} : 32'd0;
    else if (er <= 10'sd0)     y_d = {s4_q, 31'd0};
    else if (er >= 10'sd255)   y_d = {s4_q, FP_MAX_POS[30:0]};
    else                       y_d = fp_pack(s4_q, er[7:0], frac);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      out_valid <= v4_q;
      if (v4_q) y <= y_d;
    end
  end

endmodule

// File: tb/tb_plan_eval.sv
// Directed self-checking bench for plan_eval (latency, arithmetic, saturation, reset).
module tb_plan_eval;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        res;
  logic        in_valid;
  logic [31:0] x, cf1, cf2;
  logic        out_valid;
  logic [31:0] y;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_y;

  plan_eval dut (
    .clk       (clk),
    .res       (res),
    .in_valid  (in_valid),
    .x         (x),
    .cf1       (cf1),
    .cf2       (cf2),
    .out_valid (out_valid),
    .y         (y)
  );

  always #5 clk = ~clk;

  // Presents one triple for one cycle; returns at the negedge after the sampling edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    @(negedge clk);
    x = a; cf1 = b; cf2 = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; x = '0; cf1 = '0; cf2 = '0;
  endtask

  task automatic test_reset();
    res = 1'b1; in_valid = 1'b0; x = '0; cf1 = '0; cf2 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (y !== 32'h0) begin
      errors++; $display("FAIL reset_y: got %h expected 00000000", y);
    end
    res = 1'b0;
  endtask

  task automatic test_vectors(input string tag, input int n, input logic [31:0] tx[],
                              input logic [31:0] t1[], input logic [31:0] t2[],
                              input logic [31:0] ty[], input string nm[]);
    for (int i = 0; i < n; i++) begin
      send(tx[i], t1[i], t2[i]);
      repeat (LAT - 1) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL %s_%s_early: out_valid got %b expected 0", tag, nm[i], out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL %s_%s_valid: out_valid got %b expected 1", tag, nm[i], out_valid);
      end
      checks++;
      if (y !== ty[i]) begin
        errors++; $display("FAIL %s_%s_y: got %h expected %h", tag, nm[i], y, ty[i]);
      end
      last_y = ty[i];
    end
  endtask

  task automatic test_spec_cases();
    logic [31:0] tx[] = '{32'h0000_0000, 32'h3F80_0000, 32'hC000_0000, 32'h4080_0000};
    logic [31:0] t1[] = '{32'h3E7E_CE00, 32'h3E80_0000, 32'h3E80_0000, 32'h8000_0000};
    logic [31:0] t2[] = '{32'h3F00_0442, 32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000};
    logic [31:0] ty[] = '{32'h3F00_0442, 32'h3F40_0000, 32'h0000_0000, 32'h3F80_0000};
    string       nm[] = '{"zero_input", "exact_sum", "cancel", "neg_zero_slope"};
    test_vectors("spec", 4, tx, t1, t2, ty, nm);
  endtask

  task automatic test_boundaries();
    logic [31:0] tx[] = '{32'h7F00_0000, 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000,
                          32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    logic [31:0] t1[] = '{32'h4000_0000, 32'hC000_0000, 32'hBF00_0000, 32'h3F00_0000,
                          32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    logic [31:0] t2[] = '{32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000,
                          32'h4040_0000, 32'h807F_FFFF, 32'h3380_0000, 32'h33C0_0000};
`ifdef PLAN_EVAL_RNE_EN
    logic [31:0] rnd = 32'h3F80_0001;
`else
    logic [31:0] rnd = 32'h3F80_0000;
`endif
    logic [31:0] ty[] = '{32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h8000_0000, 32'h7E80_0000,
                          32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0};
    string       nm[] = '{"ovf_pos", "ovf_neg", "udf_neg", "exp255", "denorm_x",
                          "denorm_cf2", "tie_even", "round"};
    ty[7] = rnd;
    test_vectors("bnd", 8, tx, t1, t2, ty, nm);
  endtask

  task automatic test_hold();
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_valid: out_valid got %b expected 0", out_valid);
    end
    checks++;
    if (y !== last_y) begin
      errors++; $display("FAIL hold_y: got %h expected %h", y, last_y);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sx[8] = '{32'h4000_0000, 32'h3FC0_0000, 32'hC080_0000, 32'h4120_0000,
                           32'h4040_0000, 32'h3F80_0000, 32'h3F40_0000, 32'h42C8_0000};
    logic [31:0] s1[8] = '{32'h4040_0000, 32'hC000_0000, 32'hBF00_0000, 32'h3E80_0000,
                           32'h4040_0000, 32'h3F80_0000, 32'h3F40_0000, 32'hBF80_0000};
    logic [31:0] s2[8] = '{32'h3F80_0000, 32'h3F00_0000, 32'hBF80_0000, 32'hBF00_0000,
                           32'h0000_0000, 32'hBF40_0000, 32'h3EE0_0000, 32'h3F80_0000};
    logic [31:0] sy[8] = '{32'h40E0_0000, 32'hC020_0000, 32'h3F80_0000, 32'h4000_0000,
                           32'h4110_0000, 32'h3E80_0000, 32'h3F80_0000, 32'hC2C6_0000};
    logic exp_v;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      exp_v = (c >= LAT + 1) && (c < LAT + 9);
      checks++;
      if (out_valid !== exp_v) begin
        errors++; $display("FAIL stream_valid_c%0d: got %b expected %b", c, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (y !== sy[c-LAT-1]) begin
          errors++; $display("FAIL stream_y_%0d: got %h expected %h", c-LAT-1, y, sy[c-LAT-1]);
        end
      end
      if (c < 8) begin
        x = sx[c]; cf1 = s1[c]; cf2 = s2[c]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    @(negedge clk); x = 32'h4000_0000; cf1 = 32'h4040_0000; cf2 = 32'h3F80_0000; in_valid = 1'b1;
    @(negedge clk); x = 32'h3F80_0000; cf1 = 32'h3F80_0000; cf2 = 32'h3F80_0000;
    @(negedge clk); x = 32'h4120_0000; cf1 = 32'h3E80_0000; cf2 = 32'hBF00_0000;
    @(negedge clk); in_valid = 1'b0;
    #1 res = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (y !== 32'h0) begin
      errors++; $display("FAIL midrst_y: got %h expected 00000000", y);
    end
    #1 res = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid === 1'b1) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL midrst_stale: got %0d stale results expected 0", stale);
    end
    checks++;
    if (y !== 32'h0) begin
      errors++; $display("FAIL midrst_y_after: got %h expected 00000000", y);
    end
    send(32'h3F80_0000, 32'h3E80_0000, 32'h3F00_0000);
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_new_early: got %b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_new_valid: got %b expected 1", out_valid);
    end
    checks++;
    if (y !== 32'h3F40_0000) begin
      errors++; $display("FAIL midrst_new_y: got %h expected 3f400000", y);
    end
  endtask

  initial begin
    test_reset();
    test_spec_cases();
    test_boundaries();
    test_hold();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
